// File: rtl/polo_responder_pkg.sv
// ============================================================================
// Module      : polo_responder_pkg
// Description : Shared state encoding and reply-message constants for the
//               POLO responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package polo_responder_pkg;

  // Responder FSM encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

  // Largest supported message length (index is 4 bits wide)
  localparam int MSG_MAX = 16;

  // Reply bytes: "POLO\r\n"
  localparam logic [7:0] MSG_BYTE_0 = 8'h50;  // 'P'
  localparam logic [7:0] MSG_BYTE_1 = 8'h4F;  // 'O'
  localparam logic [7:0] MSG_BYTE_2 = 8'h4C;  // 'L'
  localparam logic [7:0] MSG_BYTE_3 = 8'h4F;  // 'O'
  localparam logic [7:0] MSG_BYTE_4 = 8'h0D;  // CR
  localparam logic [7:0] MSG_BYTE_5 = 8'h0A;  // LF

endpackage

`default_nettype wire

// File: rtl/polo_responder_msg_rom.sv
// ============================================================================
// Module      : polo_msg_rom
// Description : Combinational lookup of the reply-message bytes; any index
//               past the last defined byte reads as 0x00.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module polo_msg_rom
  import polo_responder_pkg::*;
(
  input  logic [3:0] idx,
  output logic [7:0] data
);

  // Index-to-byte decode
  always_comb begin
    data = 8'h00;
    case (idx)
      4'd0:    data = MSG_BYTE_0;
      4'd1:    data = MSG_BYTE_1;
      4'd2:    data = MSG_BYTE_2;
      4'd3:    data = MSG_BYTE_3;
      4'd4:    data = MSG_BYTE_4;
      4'd5:    data = MSG_BYTE_5;
      default: data = 8'h00;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/polo_responder.sv
// ============================================================================
// Module      : polo_responder
// Description : On each trigger pulse, streams the "POLO\r\n" reply (first
//               MSG_LEN bytes) to a byte-level UART transmitter over a
//               valid/ready handshake. One trigger may be queued while busy;
//               further triggers are dropped and flagged as overrun. An
//               optional idle gap follows each message.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module polo_responder
  import polo_responder_pkg::*;
#(
  parameter int MSG_LEN    = 6,
  parameter int GAP_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trigger,
  input  logic       clear_ovr,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       overrun
);

  localparam logic [3:0]  LAST_IDX = 4'(MSG_LEN - 1);
  localparam logic [15:0] GAP_LOAD = 16'(GAP_CYCLES);

  state_e      state_q,    state_d;
  logic [3:0]  idx_q,      idx_d;
  logic [15:0] gap_cnt_q,  gap_cnt_d;
  logic        pending_q,  pending_d;
  logic        overrun_q,  overrun_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q,  tx_data_d;
  logic        busy_q,     busy_d;

  logic        overrun_event;
  logic        xfer;
  logic [3:0]  rom_idx;
  logic [7:0]  rom_byte;

  // In IDLE the ROM presents byte 0 for a message start; in SEND it looks
  // one byte ahead so the next byte is ready on the transfer edge.
  assign rom_idx = (state_q == SEND) ? (idx_q + 4'd1) : 4'd0;

  polo_msg_rom u_rom (
    .idx  (rom_idx),
    .data (rom_byte)
  );

  assign xfer = tx_valid_q & tx_ready;

  // Next-state computation for the FSM, queue flag, overrun flag and outputs
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    gap_cnt_d     = gap_cnt_q;
    pending_d     = pending_q;
    overrun_d     = overrun_q;
    tx_valid_d    = tx_valid_q;
    tx_data_d     = tx_data_q;
    overrun_event = 1'b0;

    // While a message or gap is active, queue one trigger; drop the rest
    if (trigger && (state_q != IDLE)) begin
      if (pending_q) begin
        overrun_event = 1'b1;
      end else begin
        pending_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (trigger || pending_q) begin
          state_d    = SEND;
          idx_d      = 4'd0;
          tx_valid_d = 1'b1;
          tx_data_d  = rom_byte;
          // A pending request is consumed here; a trigger arriving in the
          // same cycle re-queues itself rather than counting as overrun.
          pending_d  = pending_q & trigger;
        end
      end

      SEND: begin
        if (xfer) begin
          if (idx_q == LAST_IDX) begin
            tx_valid_d = 1'b0;
            tx_data_d  = 8'h00;
            idx_d      = 4'd0;
            if (GAP_LOAD != 16'd0) begin
              state_d   = GAP;
              gap_cnt_d = GAP_LOAD;
            end else begin
              state_d   = IDLE;
            end
          end else begin
            idx_d     = idx_q + 4'd1;
            tx_data_d = rom_byte;
          end
        end
      end

      GAP: begin
        if (gap_cnt_q <= 16'd1) begin
          state_d   = IDLE;
          gap_cnt_d = 16'd0;
        end else begin
          gap_cnt_d = gap_cnt_q - 16'd1;
        end
      end

      default: begin
        state_d    = IDLE;
        idx_d      = 4'd0;
        gap_cnt_d  = 16'd0;
        tx_valid_d = 1'b0;
        tx_data_d  = 8'h00;
      end
    endcase

    // A new overrun takes priority over a simultaneous clear
    if (clear_ovr) begin
      overrun_d = 1'b0;
    end
    if (overrun_event) begin
      overrun_d = 1'b1;
    end

    busy_d = (state_d != IDLE) || pending_d;
  end

  // State and registered outputs; reset aborts any message immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= 4'd0;
      gap_cnt_q  <= 16'd0;
      pending_q  <= 1'b0;
      overrun_q  <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      gap_cnt_q  <= gap_cnt_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_polo_responder.sv
// ============================================================================
// Module      : tb_polo_responder
// Description : Directed self-checking bench for polo_responder. Three
//               instances cover the default build, a 3-cycle gap build and
//               a 4-byte message build.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_polo_responder;

  logic clk;
  logic rst;

  // Instance A: defaults
  logic       trig_a, clr_a, rdy_a, vld_a, busy_a, ovr_a;
  logic [7:0] data_a;
  // Instance B: GAP_CYCLES = 3
  logic       trig_b, clr_b, rdy_b, vld_b, busy_b, ovr_b;
  logic [7:0] data_b;
  // Instance C: MSG_LEN = 4
  logic       trig_c, clr_c, rdy_c, vld_c, busy_c, ovr_c;
  logic [7:0] data_c;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_msg [6];

  polo_responder dut_a (
    .clk(clk), .rst(rst), .trigger(trig_a), .clear_ovr(clr_a),
    .tx_data(data_a), .tx_valid(vld_a), .tx_ready(rdy_a),
    .busy(busy_a), .overrun(ovr_a)
  );

  polo_responder #(.MSG_LEN(6), .GAP_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst), .trigger(trig_b), .clear_ovr(clr_b),
    .tx_data(data_b), .tx_valid(vld_b), .tx_ready(rdy_b),
    .busy(busy_b), .overrun(ovr_b)
  );

  polo_responder #(.MSG_LEN(4), .GAP_CYCLES(0)) dut_c (
    .clk(clk), .rst(rst), .trigger(trig_c), .clear_ovr(clr_c),
    .tx_data(data_c), .tx_valid(vld_c), .tx_ready(rdy_c),
    .busy(busy_c), .overrun(ovr_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin : stim
    int         n;
    int         cnt;
    logic       prev_stall;
    logic [7:0] prev_data;

    exp_msg = '{8'h50, 8'h4F, 8'h4C, 8'h4F, 8'h0D, 8'h0A};

    trig_a = 0; clr_a = 0; rdy_a = 1;
    trig_b = 0; clr_b = 0; rdy_b = 1;
    trig_c = 0; clr_c = 0; rdy_c = 1;
    rst = 1'b1;

    // ---------------- reset state ----------------
    tick();
    tick();
    chk("rst_valid",   {31'd0, vld_a},  32'd0);
    chk("rst_data",    {24'd0, data_a}, 32'h00);
    chk("rst_busy",    {31'd0, busy_a}, 32'd0);
    chk("rst_overrun", {31'd0, ovr_a},  32'd0);
    rst = 1'b0;

    // ---------------- single message, ready tied high ----------------
    trig_a = 1;
    tick();
    trig_a = 0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("basic_valid%0d", i), {31'd0, vld_a}, 32'd1);
      chk($sformatf("basic_byte%0d", i),  {24'd0, data_a}, {24'd0, exp_msg[i]});
      tick();
    end
    chk("basic_end_valid", {31'd0, vld_a},  32'd0);
    chk("basic_end_busy",  {31'd0, busy_a}, 32'd0);

    // ---------------- ready toggling: hold until accepted ----------------
    rdy_a  = 0;
    trig_a = 1;
    tick();
    trig_a = 0;
    n = 0;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    for (int cyc = 0; cyc < 40; cyc++) begin
      rdy_a = ((cyc % 2) == 0);
      if (prev_stall) begin
        chk("toggle_hold_valid", {31'd0, vld_a},  32'd1);
        chk("toggle_hold_data",  {24'd0, data_a}, {24'd0, prev_data});
      end
      if (vld_a && rdy_a) begin
        if (n < 6) chk($sformatf("toggle_byte%0d", n), {24'd0, data_a}, {24'd0, exp_msg[n]});
        n++;
      end
      prev_stall = vld_a & ~rdy_a;
      prev_data  = data_a;
      tick();
    end
    chk("toggle_count", n, 32'd6);
    chk("toggle_idle_busy", {31'd0, busy_a}, 32'd0);
    rdy_a = 1;

    // ---------------- queued trigger and overrun ----------------
    trig_a = 1;
    tick();                       // byte 0 shown
    trig_a = 0;
    tick();                       // byte 1
    tick();                       // byte 2
    trig_a = 1;
    tick();                       // byte 3, trigger queued
    trig_a = 0;
    chk("queue_busy",       {31'd0, busy_a}, 32'd1);
    chk("queue_no_overrun", {31'd0, ovr_a},  32'd0);
    tick();                       // byte 4
    trig_a = 1;
    tick();                       // byte 5, trigger dropped
    trig_a = 0;
    chk("overrun_set", {31'd0, ovr_a}, 32'd1);
    tick();                       // back in IDLE with request pending
    chk("pend_gap_valid", {31'd0, vld_a},  32'd0);
    chk("pend_gap_busy",  {31'd0, busy_a}, 32'd1);
    tick();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("msg2_byte%0d", i), {24'd0, data_a}, {24'd0, exp_msg[i]});
      tick();
    end
    chk("msg2_end_valid", {31'd0, vld_a},  32'd0);
    chk("msg2_end_busy",  {31'd0, busy_a}, 32'd0);
    chk("overrun_sticky", {31'd0, ovr_a},  32'd1);
    clr_a = 1;
    tick();
    clr_a = 0;
    chk("overrun_cleared", {31'd0, ovr_a}, 32'd0);

    // ---------------- gap timing (GAP_CYCLES = 3) ----------------
    trig_b = 1;
    tick();                       // byte 0
    trig_b = 0;
    chk("gap_first_byte", {24'd0, data_b}, 32'h50);
    trig_b = 1;
    tick();                       // queued
    trig_b = 0;
    for (int i = 0; i < 5; i++) tick();   // last transfer of message 1
    chk("gap_msg1_done", {31'd0, vld_b},  32'd0);
    chk("gap_busy",      {31'd0, busy_b}, 32'd1);
    cnt = 0;
    while (!vld_b && cnt < 20) begin
      tick();
      cnt++;
    end
    chk("gap_latency", cnt, 32'd4);
    chk("gap_msg2_byte0", {24'd0, data_b}, 32'h50);
    for (int i = 0; i < 6; i++) tick();
    chk("gap2_valid_low", {31'd0, vld_b},  32'd0);
    chk("gap2_busy_gap",  {31'd0, busy_b}, 32'd1);
    for (int i = 0; i < 3; i++) tick();
    chk("gap2_busy_idle", {31'd0, busy_b}, 32'd0);

    // ---------------- truncated message (MSG_LEN = 4) ----------------
    trig_c = 1;
    tick();
    trig_c = 0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("short_valid%0d", i), {31'd0, vld_c}, 32'd1);
      chk($sformatf("short_byte%0d", i),  {24'd0, data_c}, {24'd0, exp_msg[i]});
      tick();
    end
    chk("short_end_valid", {31'd0, vld_c},  32'd0);
    chk("short_end_busy",  {31'd0, busy_c}, 32'd0);

    // ---------------- asynchronous reset mid-message ----------------
    trig_a = 1;
    tick();
    trig_a = 0;
    tick();                       // byte 1 on the bus
    chk("pre_rst_byte1", {24'd0, data_a}, 32'h4F);
    #2;
    rst = 1'b1;                   // between clock edges
    #1;
    chk("async_rst_valid", {31'd0, vld_a},  32'd0);
    chk("async_rst_data",  {24'd0, data_a}, 32'h00);
    chk("async_rst_busy",  {31'd0, busy_a}, 32'd0);
    tick();
    rst = 1'b0;
    trig_a = 1;
    tick();                       // first edge after release
    trig_a = 0;
    chk("restart_valid", {31'd0, vld_a},  32'd1);
    chk("restart_byte0", {24'd0, data_a}, 32'h50);
    tick();
    chk("restart_byte1", {24'd0, data_a}, 32'h4F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/polo_responder.md
POLO_RESPONDER -- requirements
Module: polo_responder

Interface
REQ-001 Parameter MSG_LEN, default 6: number of bytes in the reply message; legal range 1..16.
REQ-002 Parameter GAP_CYCLES, default 0: idle clocks inserted after the last accepted byte before the next message may start; legal range 0..65535.
REQ-003 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-high.
REQ-005 Port trigger, input, 1: one-cycle match pulse from the upstream pattern comparator; requests one reply message.
REQ-006 Port clear_ovr, input, 1: synchronous clear of overrun.
REQ-007 Port tx_data, output, 8: byte offered to the downstream byte-level UART transmitter.
REQ-008 Port tx_valid, output, 1: tx_data is valid.
REQ-009 Port tx_ready, input, 1: the transmitter accepts the byte; a transfer occurs in any cycle where tx_valid=1 and tx_ready=1.
REQ-010 Port busy, output, 1: high while a message is in progress, in gap, or pending.
REQ-011 Port overrun, output, 1: sticky flag; a trigger was dropped.

Function
REQ-012 The reply message SHALL be the fixed ASCII sequence "POLO\r\n" (0x50 0x4F 0x4C 0x4F 0x0D 0x0A), truncated to the first MSG_LEN bytes.
REQ-013 FSM states SHALL be IDLE, SEND and GAP.
REQ-014 IDLE -> SEND on trigger=1 or pending=1: at the next edge, tx_valid=1, tx_data=byte 0 and idx=0; latency from the trigger cycle to tx_valid is 1 clock.
REQ-015 In SEND, tx_data and tx_valid SHALL be held stable while tx_valid=1 and tx_ready=0.
REQ-016 On a transfer with idx<MSG_LEN-1: idx increments and tx_data=byte idx+1 at the next edge; tx_valid stays 1 with no bubble.
REQ-017 On a transfer with idx=MSG_LEN-1: tx_valid=0 at the next edge; the state goes to GAP if GAP_CYCLES>0, else to IDLE.
REQ-018 GAP SHALL last exactly GAP_CYCLES clocks, using a 16-bit down-counter, then return to IDLE.
REQ-019 A trigger while the state is not IDLE SHALL set pending if pending=0; the first tx_valid of the next message appears 1 clock after the return to IDLE.
REQ-020 A trigger while pending=1 and the state is not IDLE SHALL be dropped and SHALL set overrun.
REQ-021 A trigger in the same cycle that IDLE consumes pending SHALL set pending again (not overrun).
REQ-022 A trigger in IDLE with pending=0 SHALL start the message directly; pending stays 0.
REQ-023 clear_ovr SHALL clear overrun; if clear_ovr and a new overrun event occur in the same cycle, the set wins.
REQ-024 busy SHALL equal (state != IDLE) OR pending, registered-equivalent and glitch-free.
REQ-025 tx_ready while tx_valid=0 SHALL have no effect.
REQ-026 idx SHALL be 4 bits wide and SHALL never exceed MSG_LEN-1.

Reset
REQ-027 While rst=1: state=IDLE, idx=0, gap counter=0, pending=0, overrun=0, tx_valid=0, tx_data=0x00, busy=0.
REQ-028 rst asserted mid-message SHALL abort the message immediately and asynchronously; no partial-byte resume occurs after release.
REQ-029 The first edge after rst deasserts SHALL honour trigger normally.

Structure
REQ-030 A shared package SHALL hold the state encoding (IDLE=2'd0, SEND=2'd1, GAP=2'd2), the message byte constants, and MSG_MAX=16.
REQ-031 Message bytes SHALL come from one sub-module, polo_msg_rom (combinational, 4-bit index in, 8-bit byte out; 0x00 beyond index 5).
REQ-032 The block SHALL use no other sub-modules.

Verification
REQ-033 Trigger pulse with tx_ready tied 1, defaults -> tx_valid high for 6 consecutive clocks starting 1 clock later; bytes 50 4F 4C 4F 0D 0A; busy then falls.
REQ-034 tx_ready toggled 1/0 each cycle -> each byte held until accepted; exactly 6 transfers in order; no duplicates.
REQ-035 Second trigger during byte 2, third trigger during byte 4 -> two messages back-to-back; overrun=1; clear_ovr -> overrun=0.
REQ-036 GAP_CYCLES=3 with a pending trigger -> exactly 3+1 clocks between the last transfer of message 1 and tx_valid of message 2.
REQ-037 MSG_LEN=4 -> only 50 4F 4C 4F are sent; state returns to IDLE.
REQ-038 rst pulse asserted mid-message, between clock edges -> all outputs drop immediately to reset values; a later trigger restarts at 0x50.
